// File: rtl/soma_pkg.sv
// Shared types and constants for the serial add/subtract unit.
package soma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/soma_chunk.sv
// Combinational CHUNK-bit full adder, reused once per serial step.
module soma_chunk
  import soma_pkg::*;
#(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

endmodule

// File: rtl/soma_serie.sv
// Multi-cycle two's-complement add/subtract, CHUNK bits per clock.
// Optional build macro SOMA_SAT_EN: saturate res on signed overflow instead of wrapping.
module soma_serie
  import soma_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             carry
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("soma_serie: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t               state, state_nxt;
  logic                 go_q;
  logic                 start;
  logic [CNT_W-1:0]     cnt;
  logic                 last;

  logic [WIDTH-1:0]     a_sh, b_sh;
  logic [WIDTH-1:0]     acc;
  logic                 a_msb, b_msb;
  logic                 c;
  logic [CHUNK-1:0]     step_sum;
  logic                 step_cout;
  logic [WIDTH+CHUNK-1:0] acc_cat;

  logic                 ovf_fin;
  logic [WIDTH-1:0]     res_fin;

  assign start = go & ~go_q;
  assign last  = (cnt == CNT_W'(NCH - 1));
  assign busy  = (state != IDLE);

  // go_q comes out of reset high so a level held through reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      go_q  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      go_q  <= go;
      if (state == RUN) cnt <= cnt + CNT_W'(1);
      else              cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  soma_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (c),
    .sum  (step_sum),
    .cout (step_cout)
  );

  // Operands shift down so the active chunk always sits at bit 0
  assign acc_cat = {step_sum, acc};

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_sh  <= a;
      b_sh  <= (op == OP_SUB) ? ~b : b;
      a_msb <= a[WIDTH-1];
      b_msb <= (op == OP_SUB) ? ~b[WIDTH-1] : b[WIDTH-1];
      c     <= (op == OP_SUB);
      acc   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> CHUNK;
      b_sh  <= b_sh >> CHUNK;
      c     <= step_cout;
      acc   <= acc_cat[WIDTH+CHUNK-1:CHUNK];
    end
  end

  assign ovf_fin = (a_msb == b_msb) & (acc[WIDTH-1] != a_msb);

`ifdef SOMA_SAT_EN
  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] raw,
    input logic                    ov,
    input logic                    sign
  );
    logic signed [WIDTH-1:0] pos_max;
    logic signed [WIDTH-1:0] neg_min;
    pos_max = {1'b0, {(WIDTH-1){1'b1}}};
    neg_min = {1'b1, {(WIDTH-1){1'b0}}};
    if (!ov)  return raw;
    if (sign) return neg_min;
    return pos_max;
  endfunction

  assign res_fin = saturate(acc, ovf_fin, a_msb);
`else
  assign res_fin = acc;
`endif

  // Result stage: outputs register as FIN retires, done lines up with them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done  <= 1'b0;
      res   <= '0;
      ovf   <= 1'b0;
      carry <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (state == FIN) begin
        res   <= res_fin;
        ovf   <= ovf_fin;
        carry <= c;
      end
    end
  end

endmodule

// File: tb/tb_soma_serie.sv
// Directed vector bench for soma_serie (WIDTH=9, CHUNK=3), both SOMA_SAT_EN builds.
module tb_soma_serie;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic       op;
  logic [8:0] a;
  logic [8:0] b;
  logic       busy;
  logic       done;
  logic [8:0] res;
  logic       ovf;
  logic       carry;

  int nvec  = 0;
  int nfail = 0;

`ifdef SOMA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  soma_serie #(.WIDTH(9), .CHUNK(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res),
    .ovf   (ovf),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    logic       op;
    logic [8:0] res_w;
    logic [8:0] res_s;
    logic       ovf;
    logic       carry;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises go, waits for done (bounded), reports latency and busy cycles.
  task automatic run_op(input logic [8:0] ta, input logic [8:0] tb, input logic top,
                        output int lat, output int bcnt);
    a = ta; b = tb; op = top; go = 1'b1;
    lat = 0; bcnt = 0;
    tick();
    go = 1'b0;
    a = ~ta; b = ~tb; op = ~top;
    if (busy) bcnt++;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
  endtask

  initial begin
    int lat, bcnt, ndone, nbusy;
    logic [8:0] seen_res;
    logic       seen_carry;

    tbl[0] = '{9'h064, 9'h01B, 1'b0, 9'h07F, 9'h07F, 1'b0, 1'b0};
    tbl[1] = '{9'h0C8, 9'h064, 1'b0, 9'h12C, 9'h0FF, 1'b1, 1'b0};
    tbl[2] = '{9'h005, 9'h009, 1'b1, 9'h1FC, 9'h1FC, 1'b0, 1'b0};
    tbl[3] = '{9'h009, 9'h005, 1'b1, 9'h004, 9'h004, 1'b0, 1'b1};
    tbl[4] = '{9'h100, 9'h001, 1'b1, 9'h0FF, 9'h100, 1'b1, 1'b1};
    tbl[5] = '{9'h1FF, 9'h001, 1'b0, 9'h000, 9'h000, 1'b0, 1'b1};
    tbl[6] = '{9'h100, 9'h100, 1'b0, 9'h000, 9'h100, 1'b1, 1'b1};
    tbl[7] = '{9'h0FF, 9'h1FF, 1'b1, 9'h100, 9'h0FF, 1'b1, 1'b0};
    tbl[8] = '{9'h03F, 9'h001, 1'b0, 9'h040, 9'h040, 1'b0, 1'b0};

    // Reset with go held high: nothing may start on release
    rst_n = 1'b0; go = 1'b1; op = 1'b0; a = 9'h064; b = 9'h01B;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", res, 0);
    check("rst_ovf", ovf, 0);
    check("rst_carry", carry, 0);
    rst_n = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy || done) nbusy++;
    end
    check("held_go_no_start", nbusy, 0);
    go = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].op, lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, 4);
      check($sformatf("v%0d_busy_cycles", i), bcnt, 4);
      check($sformatf("v%0d_res", i), res, SAT ? tbl[i].res_s : tbl[i].res_w);
      check($sformatf("v%0d_ovf", i), ovf, tbl[i].ovf);
      check($sformatf("v%0d_carry", i), carry, tbl[i].carry);
    end
    tick();
    check("done_pulse_width", done, 0);
    check("res_held", res, SAT ? tbl[8].res_s : tbl[8].res_w);

    // go held for 20 cycles with a re-edge while busy: exactly one operation
    a = 9'h064; b = 9'h01B; op = 1'b0; go = 1'b1;
    ndone = 0; seen_res = '0; seen_carry = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin a = 9'h005; b = 9'h009; op = 1'b1; end
      go = (i == 1) ? 1'b0 : 1'b1;
      if (done) begin
        ndone++;
        seen_res = res;
        seen_carry = carry;
      end
    end
    check("hold_done_count", ndone, 1);
    check("hold_res", seen_res, 9'h07F);
    check("hold_carry", seen_carry, 0);
    go = 1'b0;
    tick();

    // Reset mid-RUN, release with go high, then a fresh edge
    a = 9'h0C8; b = 9'h064; op = 1'b0; go = 1'b1;
    tick();
    tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_res", res, 0);
    check("midrun_rst_ovf", ovf, 0);
    check("midrun_rst_carry", carry, 0);
    tick(); tick();
    rst_n = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy || done) nbusy++;
    end
    check("post_rst_no_start", nbusy, 0);
    go = 1'b0;
    tick();
    run_op(9'h009, 9'h005, 1'b1, lat, bcnt);
    check("post_rst_latency", lat, 4);
    check("post_rst_res", res, 9'h004);
    check("post_rst_carry", carry, 1);
    check("post_rst_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
